// File: rtl/alu_pkg.sv
// Shared types and constants for the logical-ALU command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ZERO = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_ONES = 3'd5;

  localparam int CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic andl;
    logic orl;
    logic zero;
    logic inv;
  } ctrl_t;

endpackage

// File: rtl/alu_logical.sv
// Combinational logical ALU: and/or/zero source select followed by optional inversion.
module alu_logical #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             andl,
  input  logic             orl,
  input  logic             zero,
  input  logic             inv,
  output logic [WIDTH-1:0] f
);

  logic [WIDTH-1:0] x;

  // zero selects an all-zero source; with inv that yields all ones
  always_comb begin
    x = '0;
    if (andl)       x = a & b;
    else if (orl)   x = a | b;
    else if (zero)  x = '0;
    f = inv ? ~x : x;
  end

endmodule

// File: rtl/alu_op_decode.sv
// Combinational op-code to alu_logical control-vector decoder.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ctrl_t'(4'b0000);
    illegal = 1'b0;
    case (op)
      OP_AND:  ctrl = ctrl_t'(4'b1000);
      OP_OR:   ctrl = ctrl_t'(4'b0100);
      OP_ZERO: ctrl = ctrl_t'(4'b0010);
      OP_NAND: ctrl = ctrl_t'(4'b1001);
      OP_NOR:  ctrl = ctrl_t'(4'b0101);
      OP_ONES: ctrl = ctrl_t'(4'b0011);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logical_seq.sv
// Single-command sequencer: registers operands/controls into alu_logical, waits
// SETTLE cycles, captures the result with flags and hands it out over valid/ready.
module alu_logical_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_andl,
  output logic             alu_orl,
  output logic             alu_zero,
  output logic             alu_inv,
  input  logic [WIDTH-1:0] alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_zf,
  output logic             res_nf,
  output logic             res_err
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl;
  ctrl_t            dec_ctrl;
  logic             dec_illegal;

  alu_op_decode u_dec (
    .op      (cmd_op),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ctrl    <= ctrl_t'(4'b0000);
      alu_a   <= '0;
      alu_b   <= '0;
      res_f   <= '0;
      res_zf  <= 1'b0;
      res_nf  <= 1'b0;
      res_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (dec_illegal) begin
              // illegal op never touches the ALU; report straight away
              res_f   <= '0;
              res_zf  <= 1'b0;
              res_nf  <= 1'b0;
              res_err <= 1'b1;
              state   <= ST_RESULT;
            end else begin
              alu_a <= cmd_a;
              alu_b <= cmd_b;
              ctrl  <= dec_ctrl;
              cnt   <= SETTLE_LD;
              state <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            res_f   <= alu_f;
            res_zf  <= (alu_f == '0);
            res_nf  <= alu_f[WIDTH-1];
            res_err <= 1'b0;
            ctrl    <= ctrl_t'(4'b0000);
            alu_a   <= '0;
            alu_b   <= '0;
            state   <= ST_RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_RESULT);
  assign alu_andl  = ctrl.andl;
  assign alu_orl   = ctrl.orl;
  assign alu_zero  = ctrl.zero;
  assign alu_inv   = ctrl.inv;

endmodule

// File: tb/tb_alu_logical_seq.sv
// Bench for alu_logical_seq: two instances (SETTLE=1 and SETTLE=3), each driving a real alu_logical.
module tb_alu_logical_seq;

  typedef struct packed {
    logic [7:0] f;
    logic       zf;
    logic       nf;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  logic       cmd_valid_s1, cmd_ready_s1, res_valid_s1, res_ready_s1;
  logic [2:0] cmd_op_s1;
  logic [7:0] cmd_a_s1, cmd_b_s1, alu_a_s1, alu_b_s1, alu_f_s1, res_f_s1;
  logic       alu_andl_s1, alu_orl_s1, alu_zero_s1, alu_inv_s1;
  logic       res_zf_s1, res_nf_s1, res_err_s1;

  logic       cmd_valid_s3, cmd_ready_s3, res_valid_s3, res_ready_s3;
  logic [2:0] cmd_op_s3;
  logic [7:0] cmd_a_s3, cmd_b_s3, alu_a_s3, alu_b_s3, alu_f_s3, res_f_s3;
  logic       alu_andl_s3, alu_orl_s3, alu_zero_s3, alu_inv_s3;
  logic       res_zf_s3, res_nf_s3, res_err_s3;

  wire [3:0] ctrl_s1 = {alu_andl_s1, alu_orl_s1, alu_zero_s1, alu_inv_s1};
  wire [3:0] ctrl_s3 = {alu_andl_s3, alu_orl_s3, alu_zero_s3, alu_inv_s3};
  wire [10:0] res_s1 = {res_f_s1, res_zf_s1, res_nf_s1, res_err_s1};
  wire [10:0] res_s3 = {res_f_s3, res_zf_s3, res_nf_s3, res_err_s3};

  alu_logical_seq #(.WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_s1), .cmd_ready(cmd_ready_s1), .cmd_op(cmd_op_s1),
    .cmd_a(cmd_a_s1), .cmd_b(cmd_b_s1), .alu_a(alu_a_s1), .alu_b(alu_b_s1),
    .alu_andl(alu_andl_s1), .alu_orl(alu_orl_s1), .alu_zero(alu_zero_s1), .alu_inv(alu_inv_s1),
    .alu_f(alu_f_s1), .res_valid(res_valid_s1), .res_ready(res_ready_s1),
    .res_f(res_f_s1), .res_zf(res_zf_s1), .res_nf(res_nf_s1), .res_err(res_err_s1)
  );

  alu_logical #(.WIDTH(8)) alu1 (
    .a(alu_a_s1), .b(alu_b_s1), .andl(alu_andl_s1), .orl(alu_orl_s1),
    .zero(alu_zero_s1), .inv(alu_inv_s1), .f(alu_f_s1)
  );

  alu_logical_seq #(.WIDTH(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_s3), .cmd_ready(cmd_ready_s3), .cmd_op(cmd_op_s3),
    .cmd_a(cmd_a_s3), .cmd_b(cmd_b_s3), .alu_a(alu_a_s3), .alu_b(alu_b_s3),
    .alu_andl(alu_andl_s3), .alu_orl(alu_orl_s3), .alu_zero(alu_zero_s3), .alu_inv(alu_inv_s3),
    .alu_f(alu_f_s3), .res_valid(res_valid_s3), .res_ready(res_ready_s3),
    .res_f(res_f_s3), .res_zf(res_zf_s3), .res_nf(res_nf_s3), .res_err(res_err_s3)
  );

  alu_logical #(.WIDTH(8)) alu3 (
    .a(alu_a_s3), .b(alu_b_s3), .andl(alu_andl_s3), .orl(alu_orl_s3),
    .zero(alu_zero_s3), .inv(alu_inv_s3), .f(alu_f_s3)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] r;
    r = 8'h00;
    e.err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = 8'h00;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = 8'hFF;
      default: e.err = 1'b1;
    endcase
    e.f  = r;
    e.zf = !e.err && (r == 8'h00);
    e.nf = !e.err && r[7];
    return e;
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0: return 4'b1000;
      3'd1: return 4'b0100;
      3'd2: return 4'b0010;
      3'd3: return 4'b1001;
      3'd4: return 4'b0101;
      3'd5: return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready_s1, res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1, res_s1} !== {2'b10, 31'b0}) begin
      errors++;
      $display("FAIL reset_hold_s1 got %h exp %h",
               {cmd_ready_s1, res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1, res_s1}, {2'b10, 31'b0});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready_s1, res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1, res_s1} !== {2'b10, 31'b0}) begin
      errors++;
      $display("FAIL reset_release_s1 got %h exp %h",
               {cmd_ready_s1, res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1, res_s1}, {2'b10, 31'b0});
    end
    checks++;
    if ({cmd_ready_s3, res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3, res_s3} !== {2'b10, 31'b0}) begin
      errors++;
      $display("FAIL reset_release_s3 got %h exp %h",
               {cmd_ready_s3, res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3, res_s3}, {2'b10, 31'b0});
    end
  endtask

  // legal ops back to back on the SETTLE=1 instance with res_ready tied high
  task automatic test_ops();
    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd4};
    logic [7:0] as  [7] = '{8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'h00, 8'hA8, 8'hA8};
    logic [7:0] bs  [7] = '{8'hD5, 8'hD5, 8'hD5, 8'hD5, 8'hFF, 8'hD5, 8'hD5};
    exp_t e;
    res_ready_s1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cmd_ready_s1 !== 1'b1) begin
        errors++;
        $display("FAIL ops_ready_before[%0d] got %b exp 1", i, cmd_ready_s1);
      end
      cmd_valid_s1 = 1'b1;
      cmd_op_s1 = ops[i];
      cmd_a_s1 = as[i];
      cmd_b_s1 = bs[i];
      q1.push_back(model(ops[i], as[i], bs[i]));
      @(posedge clk); #1;
      cmd_valid_s1 = 1'b0;
      cmd_op_s1 = 3'($urandom);
      cmd_a_s1 = 8'($urandom);
      cmd_b_s1 = 8'($urandom);
      checks++;
      if ({res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1} !== {1'b0, exp_ctrl(ops[i]), as[i], bs[i]}) begin
        errors++;
        $display("FAIL ops_drive[%0d] got %h exp %h", i,
                 {res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1}, {1'b0, exp_ctrl(ops[i]), as[i], bs[i]});
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1} !== 21'h100000) begin
        errors++;
        $display("FAIL ops_result_ctl[%0d] got %h exp %h", i,
                 {res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1}, 21'h100000);
      end
      if (res_valid_s1 === 1'b1 && q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (res_s1 !== e) begin
          errors++;
          $display("FAIL ops_result[%0d] got %h exp %h", i, res_s1, e);
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({cmd_ready_s1, res_valid_s1} !== 2'b10) begin
        errors++;
        $display("FAIL ops_ready_after[%0d] got %b exp 10", i, {cmd_ready_s1, res_valid_s1});
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    res_ready_s1 = 1'b1;
    for (int op = 6; op < 8; op++) begin
      cmd_valid_s1 = 1'b1;
      cmd_op_s1 = 3'(op);
      cmd_a_s1 = 8'hFF;
      cmd_b_s1 = 8'hFF;
      q1.push_back(model(3'(op), 8'hFF, 8'hFF));
      @(posedge clk); #1;
      cmd_valid_s1 = 1'b0;
      checks++;
      if ({res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1} !== 21'h100000) begin
        errors++;
        $display("FAIL illegal_ctl op=%0d got %h exp %h", op,
                 {res_valid_s1, ctrl_s1, alu_a_s1, alu_b_s1}, 21'h100000);
      end
      if (res_valid_s1 === 1'b1 && q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (res_s1 !== e) begin
          errors++;
          $display("FAIL illegal_result op=%0d got %h exp %h", op, res_s1, e);
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({cmd_ready_s1, res_valid_s1, ctrl_s1} !== 6'b100000) begin
        errors++;
        $display("FAIL illegal_after op=%0d got %b exp 100000", op, {cmd_ready_s1, res_valid_s1, ctrl_s1});
      end
    end
  endtask

  // SETTLE=3 OR held in RESULT by res_ready low while a stray command is offered
  task automatic test_backpressure();
    exp_t e;
    res_ready_s3 = 1'b0;
    cmd_valid_s3 = 1'b1;
    cmd_op_s3 = 3'd1;
    cmd_a_s3 = 8'hA8;
    cmd_b_s3 = 8'hD5;
    q3.push_back(model(3'd1, 8'hA8, 8'hD5));
    @(posedge clk); #1;
    cmd_valid_s3 = 1'b0;
    cmd_a_s3 = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3} !== {1'b0, 4'b0100, 8'hA8, 8'hD5}) begin
        errors++;
        $display("FAIL bp_drive[%0d] got %h exp %h", i,
                 {res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3}, {1'b0, 4'b0100, 8'hA8, 8'hD5});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      cmd_valid_s3 = (i == 1);
      cmd_op_s3 = 3'd0;
      checks++;
      if ({res_valid_s3, cmd_ready_s3, ctrl_s3, res_f_s3} !== {2'b10, 4'b0000, 8'hFD}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h exp %h", i,
                 {res_valid_s3, cmd_ready_s3, ctrl_s3, res_f_s3}, {2'b10, 4'b0000, 8'hFD});
      end
      @(posedge clk); #1;
    end
    cmd_valid_s3 = 1'b0;
    res_ready_s3 = 1'b1;
    if (res_valid_s3 === 1'b1 && q3.size() > 0) begin
      e = q3.pop_front();
      checks++;
      if (res_s3 !== e) begin
        errors++;
        $display("FAIL bp_result got %h exp %h", res_s3, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready_s3, res_valid_s3, ctrl_s3} !== 6'b100000) begin
      errors++;
      $display("FAIL bp_complete got %b exp 100000", {cmd_ready_s3, res_valid_s3, ctrl_s3});
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int seen;
    res_ready_s3 = 1'b1;
    cmd_valid_s3 = 1'b1;
    cmd_op_s3 = 3'd0;
    cmd_a_s3 = 8'hA8;
    cmd_b_s3 = 8'hD5;
    q3.push_back(model(3'd0, 8'hA8, 8'hD5));
    @(posedge clk); #1;
    cmd_valid_s3 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ctrl_s3 !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_in_drive got %b exp 1000", ctrl_s3);
    end
    rst_n = 1'b0;
    #1;
    q3.delete();
    checks++;
    if ({cmd_ready_s3, res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3, res_s3} !== {2'b10, 31'b0}) begin
      errors++;
      $display("FAIL rstmid_clear got %h exp %h",
               {cmd_ready_s3, res_valid_s3, ctrl_s3, alu_a_s3, alu_b_s3, res_s3}, {2'b10, 31'b0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res_valid_s3 !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_no_result got %0d valid cycles exp 0", seen);
    end
    cmd_valid_s3 = 1'b1;
    cmd_op_s3 = 3'd3;
    q3.push_back(model(3'd3, 8'hA8, 8'hD5));
    @(posedge clk); #1;
    cmd_valid_s3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (res_valid_s3 !== 1'b0 || ctrl_s3 !== 4'b1001) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_next_drive got %0d bad cycles exp 0", seen);
    end
    checks++;
    if (res_valid_s3 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_next_valid got %b exp 1", res_valid_s3);
    end else if (q3.size() > 0) begin
      e = q3.pop_front();
      checks++;
      if (res_s3 !== e) begin
        errors++;
        $display("FAIL rstmid_next_result got %h exp %h", res_s3, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready_s3, res_valid_s3, q1.size() == 0, q3.size() == 0} !== 4'b1011) begin
      errors++;
      $display("FAIL final_idle got %b exp 1011",
               {cmd_ready_s3, res_valid_s3, q1.size() == 0, q3.size() == 0});
    end
  endtask

  initial begin
    cmd_valid_s1 = 1'b0; cmd_op_s1 = 3'd0; cmd_a_s1 = 8'h00; cmd_b_s1 = 8'h00; res_ready_s1 = 1'b0;
    cmd_valid_s3 = 1'b0; cmd_op_s3 = 3'd0; cmd_a_s3 = 8'h00; cmd_b_s3 = 8'h00; res_ready_s3 = 1'b0;
    test_reset();
    test_ops();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_logical_seq.md
# alu_logical_seq

Command sequencer that sits directly around `alu_logical`. It accepts an operation plus two operands over a valid/ready handshake and drives registered `a`, `b` and control lines (`andl`, `orl`, `zero`, `inv`) into `alu_logical`. After a programmable settle time it captures `f` together with zero and negative flags, then presents the result over a second valid/ready handshake. Only one command is in flight at a time.

## Interface
- `WIDTH`, 8: operand and result width; matches `alu_logical`.
- `SETTLE`, 1: cycles between driving the ALU and sampling `f`. Legal range 1..15.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_op` input 3: operation code (see Operation).
- `cmd_a`, `cmd_b` input WIDTH: operands.
- `alu_a`, `alu_b` output WIDTH: registered operands to `alu_logical`.
- `alu_andl`, `alu_orl`, `alu_zero`, `alu_inv` output 1: registered controls to `alu_logical`.
- `alu_f` input WIDTH: result from `alu_logical`.
- `res_valid` output 1: result present.
- `res_ready` input 1: consumer accepts the result.
- `res_f` output WIDTH: captured result.
- `res_zf` output 1: result equals 0.
- `res_nf` output 1: result MSB.
- `res_err` output 1: the command had an illegal op.

## Operation
- Op encoding, given as op → {andl, orl, zero, inv}:
  - 0 AND → 1000
  - 1 OR → 0100
  - 2 ZERO → 0010
  - 3 NAND → 1001
  - 4 NOR → 0101
  - 5 ONES → 0011
  - 6 and 7 are illegal.
- FSM states: IDLE, DRIVE, RESULT.
- IDLE
  - `cmd_ready`=1 (combinational on state only).
  - On `cmd_valid` with a legal op: register operands and decoded controls, load settle counter with SETTLE-1, go to DRIVE.
  - On `cmd_valid` with an illegal op: do not drive the ALU. Set `res_f`=0, `res_zf`=0, `res_nf`=0, `res_err`=1, go to RESULT.
- DRIVE
  - Hold the ALU outputs steady.
  - When counter==0: capture `res_f`←`alu_f`, `res_zf`←(`alu_f`==0), `res_nf`←`alu_f`[WIDTH-1], `res_err`←0. Clear all four controls and both `alu_a`/`alu_b` to 0, go to RESULT.
  - Otherwise decrement the counter.
- RESULT
  - `res_valid`=1. Result registers hold until `res_valid`&&`res_ready`; on that handshake go to IDLE.
  - `cmd_valid` is ignored here (`cmd_ready`=0).
- Counter width is clog2(16)=4 bits. No wrap: it is always loaded before it is decremented.

## Timing
- Reset (async assert, sync-released usage): state IDLE, and every output register is 0: `alu_*`=0, `res_f`=0, `res_zf`=0, `res_nf`=0, `res_err`=0, counter=0. Consequently `cmd_ready`=1 and `res_valid`=0.
- Command accepted at edge N:
  - `alu_*` valid from just after N.
  - `alu_f` is sampled at edge N+SETTLE.
  - `res_valid` is high from N+SETTLE.
- Illegal op accepted at edge N: `res_valid` is high from N+1.
- With `res_ready` tied high, the result handshake occurs at edge N+SETTLE+1 and the next command can be accepted at N+SETTLE+2. Throughput is one command per SETTLE+2 cycles.
- `res_ready` low: the result and flags stay stable indefinitely and there are no extra ALU toggles.
- Reset asserted in DRIVE or RESULT: the in-flight command is dropped, outputs clear immediately (asynchronously), and there is no result handshake.
- `cmd_op`/`cmd_a`/`cmd_b` changing after acceptance has no effect.

## Structure
- Package `alu_pkg`:
  - Op code constants (OP_AND … OP_ONES).
  - FSM state encoding.
  - A 4-bit control-vector type {andl, orl, zero, inv}.
- Sub-module `alu_op_decode`: combinational op → control vector plus illegal flag. It is instantiated once. Everything else is a single sequential process plus output assigns.
- The bench instantiates `alu_logical_seq` wired to a real `alu_logical`.

## Test plan
1. Reset release, `cmd_valid`=0 → `cmd_ready`=1, `res_valid`=0, all `alu_*`=0.
2. SETTLE=1, AND with a=8'hA8, b=8'hD5, `res_ready`=1:
   - Controls are 1000 for one cycle.
   - `res_valid` is asserted one cycle after acceptance, with `res_f`=8'h80, `res_nf`=1, `res_zf`=0.
   - Then `cmd_ready`=1.
3. Same operands with OR → `res_f`=8'hFD. NAND → 8'h7F, `res_nf`=0. ZERO → 8'h00, `res_zf`=1. Then a=8'h00, b=8'hFF with NOR → 8'h00, `res_zf`=1.
4. `cmd_op`=6 → `alu_*` stays 0 throughout, `res_valid` the cycle after acceptance, `res_err`=1, `res_f`=0.
5. SETTLE=3, OR with `res_ready` held low for 4 cycles → `res_valid` stays high and `res_f` stable at 8'hFD. A `cmd_valid` pulse issued meanwhile is not accepted. Completion occurs on the edge where `res_ready` rises.
6. Assert `rst_n`=0 in the second DRIVE cycle (SETTLE=3) → all outputs are 0 immediately. After release, state is IDLE, `res_valid` never pulsed, and the next command completes normally.
